// File: rtl/matrix_pkg.sv
// Shared constants, reader state encoding and element addressing for the matrix stream reader.
package matrix_pkg;
  localparam int unsigned DATA_WIDTH          = 8;
  localparam int unsigned MAX_SIZE            = 5;
  localparam int unsigned MEM_DEPTH           = MAX_SIZE * MAX_SIZE;
  localparam int unsigned MAX_MATRIX_PER_SIZE = 4;
  localparam int unsigned SEL_IDX_W           = 2;
  localparam int unsigned DIM_W               = 3;
  localparam int unsigned ADDR_W              = 5;

  typedef enum logic [1:0] {StIdle, StLookup, StStream, StFinish} reader_state_e;

  // Row-major packed address; max 4*5+4 = 24 fits in 5 bits.
  function automatic logic [ADDR_W-1:0] elem_addr(input logic [DIM_W-1:0] r,
                                                  input logic [DIM_W-1:0] c,
                                                  input logic [DIM_W-1:0] cols);
    return ADDR_W'(r) * ADDR_W'(cols) + ADDR_W'(c);
  endfunction
endpackage

// File: rtl/matrix_stream_reader_if.sv
// Command, storage-query and element-stream signals of the matrix stream reader.
// cmd_transpose exists only when MATRIX_READER_TRANSPOSE_EN is defined.
interface matrix_stream_reader_if;
  import matrix_pkg::*;

  logic                            cmd_valid;
  logic                            cmd_ready;
  logic [DIM_W-1:0]                cmd_row;
  logic [DIM_W-1:0]                cmd_col;
  logic [SEL_IDX_W-1:0]            cmd_idx;
`ifdef MATRIX_READER_TRANSPOSE_EN
  logic                            cmd_transpose;
`endif
  logic [DIM_W-1:0]                req_scale_row;
  logic [DIM_W-1:0]                req_scale_col;
  logic [SEL_IDX_W-1:0]            req_idx;
  logic                            st_matrix_valid;
  logic [DIM_W-1:0]                st_matrix_row;
  logic [DIM_W-1:0]                st_matrix_col;
  logic [MEM_DEPTH*DATA_WIDTH-1:0] st_matrix_data;
  logic                            out_valid;
  logic                            out_ready;
  logic [DATA_WIDTH-1:0]           out_data;
  logic [DIM_W-1:0]                out_r;
  logic [DIM_W-1:0]                out_c;
  logic                            out_eol;
  logic                            out_last;
  logic                            done;
  logic                            err;

  // Reader side.
  modport master (
    input  cmd_valid, cmd_row, cmd_col, cmd_idx,
`ifdef MATRIX_READER_TRANSPOSE_EN
    input  cmd_transpose,
`endif
    input  st_matrix_valid, st_matrix_row, st_matrix_col, st_matrix_data, out_ready,
    output cmd_ready, req_scale_row, req_scale_col, req_idx,
    output out_valid, out_data, out_r, out_c, out_eol, out_last, done, err
  );

  // Host / storage / consumer side.
  modport slave (
    output cmd_valid, cmd_row, cmd_col, cmd_idx,
`ifdef MATRIX_READER_TRANSPOSE_EN
    output cmd_transpose,
`endif
    output st_matrix_valid, st_matrix_row, st_matrix_col, st_matrix_data, out_ready,
    input  cmd_ready, req_scale_row, req_scale_col, req_idx,
    input  out_valid, out_data, out_r, out_c, out_eol, out_last, done, err
  );
endinterface

// File: rtl/matrix_stream_reader_cursor.sv
// Element cursor: r/c counters with wrap, row-major or column-major order, eol/last flags
// and the packed buffer address of the current element.
module matrix_elem_cursor
  import matrix_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              advance_i,
  input  logic              transpose_i,
  input  logic [DIM_W-1:0]  rows_i,
  input  logic [DIM_W-1:0]  cols_i,
  output logic [DIM_W-1:0]  out_r_o,
  output logic [DIM_W-1:0]  out_c_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              eol_o,
  output logic              last_o
);
  logic [DIM_W-1:0] r_q, r_d, c_q, c_d;
  logic             row_end, col_end;

  assign row_end = (r_q == rows_i - 3'd1);
  assign col_end = (c_q == cols_i - 3'd1);

  always_comb begin
    r_d = r_q;
    c_d = c_q;
    if (clear_i) begin
      r_d = '0;
      c_d = '0;
    end else if (advance_i) begin
      if (transpose_i) begin
        if (row_end) begin
          r_d = '0;
          c_d = c_q + 3'd1;
        end else begin
          r_d = r_q + 3'd1;
        end
      end else begin
        if (col_end) begin
          c_d = '0;
          r_d = r_q + 3'd1;
        end else begin
          c_d = c_q + 3'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
      c_q <= '0;
    end else begin
      r_q <= r_d;
      c_q <= c_d;
    end
  end

  // Transposed order reports indices of the transposed matrix.
  assign out_r_o = transpose_i ? c_q : r_q;
  assign out_c_o = transpose_i ? r_q : c_q;
  assign addr_o  = elem_addr(r_q, c_q, cols_i);
  assign eol_o   = transpose_i ? row_end : col_end;
  assign last_o  = row_end && col_end;
endmodule

// File: rtl/matrix_stream_reader.sv
// Snapshots one matrix from storage and streams its elements over valid/ready.
// Define MATRIX_READER_TRANSPOSE_EN to add column-major streaming via cmd_transpose.
module matrix_stream_reader
  import matrix_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  matrix_stream_reader_if.master bus
);
  reader_state_e         state_q, state_d;
  logic [DIM_W-1:0]      req_row_q, req_col_q, rows_q, cols_q;
  logic [SEL_IDX_W-1:0]  req_idx_q;
  logic [DATA_WIDTH-1:0] buf_q [MEM_DEPTH];
  logic                  err_q, err_d;
  logic                  cmd_fire, cmd_ok, hit, load, advance, streaming, transpose;
  logic [DIM_W-1:0]      cur_r, cur_c;
  logic [ADDR_W-1:0]     cur_addr;
  logic                  cur_eol, cur_last;

  assign streaming = (state_q == StStream);
  assign cmd_fire  = bus.cmd_valid && (state_q == StIdle);
  assign cmd_ok    = (bus.cmd_row != '0) && (32'(bus.cmd_row) <= MAX_SIZE) &&
                     (bus.cmd_col != '0) && (32'(bus.cmd_col) <= MAX_SIZE) &&
                     (32'(bus.cmd_idx) < MAX_MATRIX_PER_SIZE);
  assign hit       = bus.st_matrix_valid && (bus.st_matrix_row == req_row_q) &&
                     (bus.st_matrix_col == req_col_q);
  assign load      = (state_q == StLookup) && hit;
  assign advance   = streaming && bus.out_ready;

`ifdef MATRIX_READER_TRANSPOSE_EN
  logic transpose_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      transpose_q <= 1'b0;
    end else if (cmd_fire && cmd_ok) begin
      transpose_q <= bus.cmd_transpose;
    end
  end
  assign transpose = transpose_q;
`else
  assign transpose = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cmd_fire) begin
          if (cmd_ok) state_d = StLookup;
          else        err_d   = 1'b1;
        end
      end
      StLookup: begin
        if (hit) begin
          state_d = StStream;
        end else begin
          state_d = StIdle;
          err_d   = 1'b1;
        end
      end
      StStream: if (bus.out_ready && cur_last) state_d = StFinish;
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      err_q     <= 1'b0;
      req_row_q <= 3'd1;
      req_col_q <= 3'd1;
      req_idx_q <= '0;
      rows_q    <= 3'd1;
      cols_q    <= 3'd1;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      if (cmd_fire && cmd_ok) begin
        req_row_q <= bus.cmd_row;
        req_col_q <= bus.cmd_col;
        req_idx_q <= bus.cmd_idx;
      end
      if (load) begin
        rows_q <= bus.st_matrix_row;
        cols_q <= bus.st_matrix_col;
      end
    end
  end

  // Snapshot decouples the stream from later storage writes.
  always_ff @(posedge clk) begin
    if (load) begin
      for (int k = 0; k < int'(MEM_DEPTH); k++) begin
        buf_q[k] <= bus.st_matrix_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  matrix_elem_cursor u_cursor (
    .clk         (clk),
    .rst         (rst),
    .clear_i     (load),
    .advance_i   (advance),
    .transpose_i (transpose),
    .rows_i      (rows_q),
    .cols_i      (cols_q),
    .out_r_o     (cur_r),
    .out_c_o     (cur_c),
    .addr_o      (cur_addr),
    .eol_o       (cur_eol),
    .last_o      (cur_last)
  );

  assign bus.cmd_ready     = (state_q == StIdle);
  assign bus.req_scale_row = req_row_q;
  assign bus.req_scale_col = req_col_q;
  assign bus.req_idx       = req_idx_q;
  assign bus.out_valid     = streaming;
  assign bus.out_data      = streaming ? buf_q[cur_addr] : '0;
  assign bus.out_r         = streaming ? cur_r : '0;
  assign bus.out_c         = streaming ? cur_c : '0;
  assign bus.out_eol       = streaming && cur_eol;
  assign bus.out_last      = streaming && cur_last;
  assign bus.done          = (state_q == StFinish);
  assign bus.err           = err_q;
endmodule

// File: tb/tb_matrix_stream_reader.sv
// Self-checking bench: storage model, expected-element queue and directed stimulus.
module tb_matrix_stream_reader;
  import matrix_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  matrix_stream_reader_if bus ();

  matrix_stream_reader dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [7:0] data;
    logic [2:0] r;
    logic [2:0] c;
    logic       eol;
    logic       last;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       e;
  int         n_checks = 0;
  int         n_pass = 0;
  logic [7:0] smem [256][25];
  logic       svld [256];
  int         sk;

  function automatic int sidx(input int row, input int col, input int idx);
    return (row * 8 + col) * 4 + idx;
  endfunction

  // Storage model: combinational query on req_*.
  assign sk = sidx(int'(bus.req_scale_row), int'(bus.req_scale_col), int'(bus.req_idx));
  always_comb begin
    bus.st_matrix_valid = svld[sk];
    bus.st_matrix_row   = bus.req_scale_row;
    bus.st_matrix_col   = bus.req_scale_col;
    bus.st_matrix_data  = '0;
    for (int i = 0; i < 25; i++) bus.st_matrix_data[i*8 +: 8] = smem[sk][i];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic store_seq(input int row, input int col, input int idx, input int first);
    for (int i = 0; i < 25; i++) smem[sidx(row, col, idx)][i] = 8'(first + i);
    svld[sidx(row, col, idx)] = 1'b1;
  endtask

  // Expected stream from the matrix's definition, not from any cursor mechanics.
  task automatic build(input int rows, input int cols, input int idx, input bit tr);
    exp_t x;
    if (!tr) begin
      for (int r = 0; r < rows; r++)
        for (int c = 0; c < cols; c++) begin
          x.data = smem[sidx(rows, cols, idx)][r*cols + c];
          x.r = 3'(r); x.c = 3'(c);
          x.eol = (c == cols - 1); x.last = (r == rows - 1) && (c == cols - 1);
          exp_q.push_back(x);
        end
    end else begin
      for (int c = 0; c < cols; c++)
        for (int r = 0; r < rows; r++) begin
          x.data = smem[sidx(rows, cols, idx)][r*cols + c];
          x.r = 3'(c); x.c = 3'(r);
          x.eol = (r == rows - 1); x.last = (r == rows - 1) && (c == cols - 1);
          exp_q.push_back(x);
        end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents a command for one cycle; returns in cycle T+1.
  task automatic issue(input int row, input int col, input int idx, input bit tr,
                       input bit expect_stream);
    bus.cmd_row   = 3'(row);
    bus.cmd_col   = 3'(col);
    bus.cmd_idx   = 2'(idx);
`ifdef MATRIX_READER_TRANSPOSE_EN
    bus.cmd_transpose = tr;
`endif
    bus.cmd_valid = 1'b1;
    if (expect_stream) build(row, col, idx, tr);
    step();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (!bus.done && n < budget) begin
      step();
      n++;
    end
    check({name, "_done"}, 32'(bus.done), 32'd1);
    check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  // Compare process: every presented element against the head of the model queue.
  always @(negedge clk) begin
    if (!rst && bus.out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", 32'(bus.out_valid), 32'd0);
      end else begin
        e = exp_q[0];
        check("stream_data", 32'(bus.out_data), 32'(e.data));
        check("stream_r", 32'(bus.out_r), 32'(e.r));
        check("stream_c", 32'(bus.out_c), 32'(e.c));
        check("stream_eol", 32'(bus.out_eol), 32'(e.eol));
        check("stream_last", 32'(bus.out_last), 32'(e.last));
        if (bus.out_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 256; i++) svld[i] = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_row   = '0;
    bus.cmd_col   = '0;
    bus.cmd_idx   = '0;
`ifdef MATRIX_READER_TRANSPOSE_EN
    bus.cmd_transpose = 1'b0;
`endif
    bus.out_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_done_err", 32'({bus.done, bus.err}), 32'd0);
    check("rst_req", 32'({bus.req_scale_row, bus.req_scale_col, bus.req_idx}),
          32'({3'd1, 3'd1, 2'd0}));

    // 2x3 row-major, full-rate consumer, exact latency.
    store_seq(2, 3, 0, 1);
    issue(2, 3, 0, 1'b0, 1'b1);
    check("lat_t1_valid", 32'(bus.out_valid), 32'd0);
    check("lat_t1_req", 32'({bus.req_scale_row, bus.req_scale_col, bus.req_idx}),
          32'({3'd2, 3'd3, 2'd0}));
    step();
    check("lat_t2_valid", 32'(bus.out_valid), 32'd1);
    check("lat_t2_data", 32'(bus.out_data), 32'd1);
    step();
    step();
    check("e3_data_eol", 32'({bus.out_data, bus.out_eol, bus.out_last}), 32'({8'd3, 2'b10}));
    step();
    step();
    step();
    check("e6_data_last", 32'({bus.out_data, bus.out_eol, bus.out_last}), 32'({8'd6, 2'b11}));
    step();
    check("t8_done", 32'({bus.done, bus.out_valid, bus.cmd_ready}), 32'(3'b100));
    step();
    check("t9_idle", 32'({bus.done, bus.cmd_ready}), 32'(2'b01));

    // Backpressure pattern 1,0,0,1,...
    issue(2, 3, 0, 1'b0, 1'b1);
    for (int n = 0; n < 80 && !bus.done; n++) begin
      bus.out_ready = (n % 4 == 0) || (n % 4 == 3);
      step();
    end
    check("stall_done", 32'(bus.done), 32'd1);
    check("stall_drained", 32'(exp_q.size()), 32'd0);
    bus.out_ready = 1'b1;
    step();

    // Lookup miss: only idx0 exists at 3x3.
    store_seq(3, 3, 0, 50);
    issue(3, 3, 2, 1'b0, 1'b0);
    check("miss_t1_err", 32'(bus.err), 32'd0);
    step();
    check("miss_t2", 32'({bus.err, bus.cmd_ready, bus.out_valid}), 32'(3'b110));
    step();
    check("miss_t3_err", 32'(bus.err), 32'd0);

    // Out-of-range commands rejected directly from IDLE.
    issue(6, 1, 0, 1'b0, 1'b0);
    check("bad_row6", 32'({bus.err, bus.cmd_ready}), 32'(2'b11));
    check("bad_row6_req", 32'({bus.req_scale_row, bus.req_scale_col, bus.req_idx}),
          32'({3'd3, 3'd3, 2'd2}));
    step();
    check("bad_row6_after", 32'({bus.err, bus.out_valid}), 32'd0);
    issue(0, 2, 1, 1'b0, 1'b0);
    check("bad_row0", 32'({bus.err, bus.cmd_ready}), 32'(2'b11));
    step();

    // Storage overwrite during the stream must not reach the output.
    issue(2, 3, 0, 1'b0, 1'b1);
    step();
    step();
    store_seq(2, 3, 0, 9);
    wait_done("overwrite", 20);
    store_seq(2, 3, 0, 1);
    step();

    // Reset mid-stream.
    issue(2, 3, 0, 1'b0, 1'b1);
    step();
    step();
    rst = 1'b1;
    exp_q.delete();
    step();
    rst = 1'b0;
    check("midrst_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_req", 32'({bus.req_scale_row, bus.req_scale_col, bus.req_idx}),
          32'({3'd1, 3'd1, 2'd0}));
    for (int n = 0; n < 3; n++) begin
      step();
      check("midrst_quiet", 32'({bus.done, bus.err, bus.out_valid}), 32'd0);
    end

    // 1x1 matrix.
    store_seq(1, 1, 3, 8'hA5);
    issue(1, 1, 3, 1'b0, 1'b1);
    step();
    check("one_elem", 32'({bus.out_data, bus.out_eol, bus.out_last}), 32'({8'hA5, 2'b11}));
    step();
    check("one_done", 32'(bus.done), 32'd1);
    step();

`ifdef MATRIX_READER_TRANSPOSE_EN
    issue(2, 3, 0, 1'b1, 1'b1);
    step();
    check("tr_e0", 32'(bus.out_data), 32'd1);
    step();
    check("tr_e1", 32'({bus.out_data, bus.out_r, bus.out_c, bus.out_eol}),
          32'({8'd4, 3'd0, 3'd1, 1'b1}));
    wait_done("transpose", 20);
    step();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
